// File: rtl/viterbi_decoder_if.sv
// viterbi_decoder_if: symbol handshake, flush request and serial decoded-bit output
interface viterbi_decoder_if;
  logic [1:0] sym_i;
  logic sym_valid_i;
  logic sym_ready_o;
  logic flush_i;
  logic data_serial_o;
  logic valid_serial_o;
  modport master(output sym_i, sym_valid_i, flush_i, input sym_ready_o, data_serial_o, valid_serial_o);
  modport slave(input sym_i, sym_valid_i, flush_i, output sym_ready_o, data_serial_o, valid_serial_o);
endinterface

// File: rtl/viterbi_decoder.sv
// viterbi_decoder: hard-decision K=3 (7,5) Viterbi decoder with register-exchange survivors.
// Defining VITERBI_FLUSH_EN adds flush_i and the FLUSH state that drains the survivor tail.
module viterbi_decoder #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W = 4
) (
  input logic clk,
  input logic rst_n,
  viterbi_decoder_if.slave io
);
  localparam int CW = $clog2(TB_DEPTH + 1);
  localparam int RW = $clog2(TB_DEPTH);
  localparam logic [PM_W-1:0] PM_MAX = '1;
  localparam logic [CW-1:0] DEPTH = CW'(TB_DEPTH);
  logic [PM_W-1:0] pm [4];
  logic [PM_W-1:0] cand0 [4];
  logic [PM_W-1:0] cand1 [4];
  logic [PM_W-1:0] pm_raw [4];
  logic [PM_W-1:0] pm_new [4];
  logic [TB_DEPTH-1:0] path [4];
  logic [TB_DEPTH-1:0] path_new [4];
  logic [3:0] sel;
  logic [PM_W-1:0] pm_min;
  logic [1:0] best, best_new;
  logic [CW-1:0] c, c_next;
  logic accept, run_out, go, flush_bit;
  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return s[PM_W] ? PM_MAX : s[PM_W-1:0];
  endfunction
  function automatic logic [1:0] bm(input logic [1:0] p, input logic u, input logic [1:0] sym);
    logic [1:0] x;
    x = sym ^ {u ^ p[1] ^ p[0], u ^ p[0]};
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction
  // next state n={u,s1} is reached from {s1,0} and {s1,1}; ties favour s0=0
  always_comb begin
    pm_min = PM_MAX;
    for (int n = 0; n < 4; n++) begin
      cand0[n] = sat_add(pm[{n[0], 1'b0}], bm({n[0], 1'b0}, n[1], io.sym_i));
      cand1[n] = sat_add(pm[{n[0], 1'b1}], bm({n[0], 1'b1}, n[1], io.sym_i));
      sel[n] = cand1[n] < cand0[n];
      pm_raw[n] = sel[n] ? cand1[n] : cand0[n];
      path_new[n] = {path[{n[0], sel[n]}][TB_DEPTH-2:0], n[1]};
      if (pm_raw[n] < pm_min) pm_min = pm_raw[n];
    end
    best_new = 2'd3;
    for (int n = 3; n >= 0; n--) begin
      pm_new[n] = pm_raw[n] - pm_min;
      if (pm_new[n] == '0) best_new = 2'(n);
    end
  end
  assign accept = io.sym_valid_i & io.sym_ready_o;
  assign c_next = accept && c != DEPTH ? c + 1'b1 : c;
  assign run_out = accept && c_next == DEPTH;
`ifdef VITERBI_FLUSH_EN
  typedef enum logic {RUN, FLUSH} state_t;
  state_t st;
  logic [1:0] best_f;
  logic [RW-1:0] rem, r;
  logic [TB_DEPTH-1:0] tail;
  assign go = st == RUN && io.flush_i && c_next != '0;
  assign r = c_next == DEPTH ? RW'(TB_DEPTH - 1) : RW'(c_next);
  assign tail = accept ? path_new[best_new] : path[best];
  assign flush_bit = go && tail[r - 1'b1];
`else
  logic unused_flush;
  assign unused_flush = io.flush_i;
  assign go = 1'b0;
  assign flush_bit = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm <= '{'0, PM_MAX, PM_MAX, PM_MAX};
      path <= '{default: '0};
      c <= '0;
      best <= '0;
      io.sym_ready_o <= 1'b1;
      io.data_serial_o <= 1'b0;
      io.valid_serial_o <= 1'b0;
`ifdef VITERBI_FLUSH_EN
      st <= RUN;
      best_f <= '0;
      rem <= '0;
    end else if (st == FLUSH) begin
      io.valid_serial_o <= rem != '0;
      io.data_serial_o <= rem != '0 && path[best_f][rem - 1'b1];
      if (rem != '0) rem <= rem - 1'b1;
      else begin
        st <= RUN;
        io.sym_ready_o <= 1'b1;
        pm <= '{'0, PM_MAX, PM_MAX, PM_MAX};
        path <= '{default: '0};
        c <= '0;
        best <= '0;
      end
`endif
    end else begin
      if (accept) begin
        pm <= pm_new;
        path <= path_new;
        best <= best_new;
      end
      c <= c_next;
      io.valid_serial_o <= run_out | go;
      io.data_serial_o <= run_out ? path_new[best_new][TB_DEPTH-1] : flush_bit;
`ifdef VITERBI_FLUSH_EN
      // a same-cycle RUN strobe takes this slot, so every tail bit is deferred by one
      if (go) begin
        st <= FLUSH;
        io.sym_ready_o <= 1'b0;
        best_f <= accept ? best_new : best;
        rem <= run_out ? r : r - 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_viterbi_decoder.sv
// tb_viterbi_decoder: table-driven directed test of viterbi_decoder (TB_DEPTH=16, PM_W=4)
module tb_viterbi_decoder;
  typedef struct {
    logic [31:0] msg;
    int n;
    int f0;
    int f1;
    bit rst;
    int n_run;
    int n_flush;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int fails = 0;
  logic [1:0] enc_s;
  logic [31:0] dec;
  int nd;
  vec_t tbl [4];
  always #5 clk = ~clk;
  viterbi_decoder_if io();
  viterbi_decoder #(.TB_DEPTH(16), .PM_W(4)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic enc(input logic u, output logic [1:0] s);
    s = {u ^ enc_s[1] ^ enc_s[0], u ^ enc_s[0]};
    enc_s = {u, enc_s[1]};
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    if (io.valid_serial_o) begin
      if (nd < 32) dec[nd] = io.data_serial_o;
      nd++;
    end
  endtask
  task automatic chk_rst_vals(input string tag);
    chk({tag, " valid"}, io.valid_serial_o, 0);
    chk({tag, " data"}, io.data_serial_o, 0);
    chk({tag, " ready"}, io.sym_ready_o, 1);
  endtask
  task automatic do_reset();
    io.sym_valid_i = 1'b0;
    io.flush_i = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_rst_vals("in_reset");
    @(negedge clk) rst_n = 1'b1;
  endtask
  task automatic run_case(input vec_t v, input string tag);
    logic [1:0] s;
    int total;
    if (v.rst) do_reset();
    enc_s = 2'b00;
    nd = 0;
    dec = '0;
`ifdef VITERBI_FLUSH_EN
    total = v.n;
`else
    total = v.n + 15;
`endif
    for (int k = 1; k <= total; k++) begin
      enc(k <= v.n ? v.msg[k-1] : 1'b0, s);
      if (k == v.f0) s[1] = ~s[1];
      if (k == v.f1) s[0] = ~s[0];
      io.sym_i = s;
      io.sym_valid_i = 1'b1;
`ifndef VITERBI_FLUSH_EN
      io.flush_i = k == v.n + 1;
`endif
      step();
      chk($sformatf("%s strobe k=%0d", tag, k), io.valid_serial_o, k >= 16);
`ifndef VITERBI_FLUSH_EN
      chk($sformatf("%s ready k=%0d", tag, k), io.sym_ready_o, 1);
`endif
    end
    io.sym_valid_i = 1'b0;
    io.flush_i = 1'b0;
    chk({tag, " run strobes"}, nd, v.n_run);
`ifdef VITERBI_FLUSH_EN
    io.flush_i = 1'b1;
    step();
    io.flush_i = 1'b0;
    for (int j = 0; j < v.n_flush; j++) begin
      if (j > 0) step();
      chk($sformatf("%s flush strobe %0d", tag, j), io.valid_serial_o, 1);
      chk($sformatf("%s flush ready %0d", tag, j), io.sym_ready_o, 0);
    end
    step();
    chk({tag, " after flush valid"}, io.valid_serial_o, 0);
    chk({tag, " after flush ready"}, io.sym_ready_o, 1);
`endif
    chk({tag, " flush strobes"}, nd - v.n_run, v.n_flush);
    chk({tag, " decoded"}, dec, v.exp);
    for (int b = 0; b * 8 + 8 <= v.n; b++)
      chk($sformatf("%s sipo byte %0d", tag, b), dec[b*8 +: 8], v.exp[b*8 +: 8]);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0] s;
    io.sym_i = 2'b00;
    io.sym_valid_i = 1'b0;
    io.flush_i = 1'b0;
`ifdef VITERBI_FLUSH_EN
    tbl[0] = '{32'h3C00FFA5, 32, 0, 0, 1'b0, 17, 15, 32'h3C00FFA5};
    tbl[1] = '{32'h3C00FFA5, 32, 4, 13, 1'b0, 17, 15, 32'h3C00FFA5};
    tbl[2] = '{32'h0000000D, 5, 0, 0, 1'b0, 0, 5, 32'h0000000D};
    tbl[3] = '{32'h000B5E39, 20, 0, 0, 1'b0, 5, 15, 32'h000B5E39};
`else
    tbl[0] = '{32'h3C00FFA5, 32, 0, 0, 1'b0, 32, 0, 32'h3C00FFA5};
    tbl[1] = '{32'h3C00FFA5, 32, 4, 13, 1'b1, 32, 0, 32'h3C00FFA5};
    tbl[2] = '{32'h0000000D, 5, 0, 0, 1'b1, 5, 0, 32'h0000000D};
    tbl[3] = '{32'h000B5E39, 20, 0, 0, 1'b1, 20, 0, 32'h000B5E39};
`endif
    do_reset();
    #1;
    chk_rst_vals("after_reset");
    enc_s = 2'b00;
    nd = 0;
    for (int k = 1; k <= 18; k++) begin
      enc(1'b1, s);
      io.sym_i = s;
      io.sym_valid_i = 1'b1;
      step();
    end
    io.sym_valid_i = 1'b0;
    chk("midrst pre valid", io.valid_serial_o, 1);
    chk("midrst pre data", io.data_serial_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_rst_vals("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) run_case(tbl[i], $sformatf("case%0d", i));
`ifdef VITERBI_FLUSH_EN
    enc_s = 2'b00;
    nd = 0;
    dec = '0;
    for (int k = 0; k < 4; k++) begin
      enc(k != 2, s);
      io.sym_i = s;
      io.sym_valid_i = 1'b1;
      io.flush_i = k == 3;
      step();
    end
    io.sym_valid_i = 1'b0;
    io.flush_i = 1'b0;
    chk("collide ready", io.sym_ready_o, 0);
    repeat (3) step();
    chk("collide last ready", io.sym_ready_o, 0);
    step();
    chk("collide end valid", io.valid_serial_o, 0);
    chk("collide end ready", io.sym_ready_o, 1);
    chk("collide strobes", nd, 4);
    chk("collide bits", dec[3:0], 4'b1011);
`else
    io.flush_i = 1'b1;
    step();
    io.flush_i = 1'b0;
    chk("idle flush valid", io.valid_serial_o, 0);
    chk("idle flush ready", io.sym_ready_o, 1);
    step();
    chk("idle flush valid2", io.valid_serial_o, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
